// File: rtl/triangle_assembler_if.sv
// Vertex-in / triangle-out bundle for triangle_assembler.
//   slave  : the assembler side (vertex stream in, triangle stream and status out)
//   master : the side driving vertices and consuming triangles
interface triangle_assembler_if;
  localparam int unsigned VTX_W = 32;
  localparam int unsigned MAT_W = 12;
  localparam int unsigned CNT_W = 16;

  logic                            flush_in;
  logic                            valid_in;
  logic [3:0][VTX_W-1:0]           vertex_in;
  logic [MAT_W-1:0]                material_in;
  logic                            valid_out;
  logic                            ready_in;
  logic [2:0][3:0][VTX_W-1:0]      triangle_out;
  logic [MAT_W-1:0]                material_out;
  logic                            overflow_out;
  logic [CNT_W-1:0]                culled_count_out;
  logic [CNT_W-1:0]                tri_count_out;

  modport master (
    output flush_in, valid_in, vertex_in, material_in, ready_in,
    input  valid_out, triangle_out, material_out, overflow_out,
           culled_count_out, tri_count_out
  );

  modport slave (
    input  flush_in, valid_in, vertex_in, material_in, ready_in,
    output valid_out, triangle_out, material_out, overflow_out,
           culled_count_out, tri_count_out
  );
endinterface

// File: rtl/triangle_assembler.sv
// Collects clip-space vertices into triangles, rejects triangles entirely
// behind the eye (all w <= 0), and buffers survivors in a small FIFO toward
// the rasterizer. The input never stalls; a triangle arriving at a full FIFO
// is dropped and flagged on the sticky overflow output.
// Ports:
//   clk_in    clock
//   rst_n_in  asynchronous active-low reset
//   bus       triangle_assembler_if.slave (vertex stream, triangle stream, status)
module triangle_assembler #(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned CULL_ENABLE = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  triangle_assembler_if.slave  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned VTX_W = 32;
  localparam int unsigned MAT_W = 12;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {V0, V1, V2} state_t;

  state_t                                       r_state;
  state_t                                       w_state_nxt;
  logic                                         w_wr_slot0;
  logic                                         w_wr_slot1;
  logic                                         w_complete;

  logic [1:0][3:0][VTX_W-1:0]                   r_slot_vtx;
  logic [1:0][MAT_W-1:0]                        r_slot_mat;

  logic [FIFO_DEPTH-1:0][2:0][3:0][VTX_W-1:0]   r_mem_tri;
  logic [FIFO_DEPTH-1:0][MAT_W-1:0]             r_mem_mat;
  logic [PTR_W:0]                               r_wptr;
  logic [PTR_W:0]                               r_rptr;

  logic                                         r_overflow;
  logic [CNT_W-1:0]                             r_culled_cnt;
  logic [CNT_W-1:0]                             r_tri_cnt;

  logic                                         w_empty;
  logic                                         w_full;
  logic                                         w_pop;
  logic                                         w_all_behind;
  logic                                         w_cull;
  logic                                         w_push;
  logic                                         w_drop;
  logic [2:0][3:0][VTX_W-1:0]                   w_tri_new;

  // w <= 0 includes -0 and +0; NaN/Inf with sign clear counts as in front
  function automatic logic le_zero(input logic [VTX_W-1:0] w);
    return w[VTX_W-1] | (w[VTX_W-2:0] == (VTX_W-1)'(0));
  endfunction

  // Collector state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= V0;
    else           r_state <= w_state_nxt;
  end

  // Collector next state; flush wins over a same-cycle vertex
  always_comb begin
    w_state_nxt = r_state;
    w_wr_slot0  = 1'b0;
    w_wr_slot1  = 1'b0;
    w_complete  = 1'b0;
    if (bus.flush_in) begin
      w_state_nxt = V0;
    end else if (bus.valid_in) begin
      unique case (r_state)
        V0: begin
          w_state_nxt = V1;
          w_wr_slot0  = 1'b1;
        end
        V1: begin
          w_state_nxt = V2;
          w_wr_slot1  = 1'b1;
        end
        V2: begin
          w_state_nxt = V0;
          w_complete  = 1'b1;
        end
        default: w_state_nxt = V0;
      endcase
    end
  end

  // Vertex slots; the third vertex goes straight into the FIFO
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_slot_vtx <= '0;
      r_slot_mat <= '0;
    end else begin
      if (w_wr_slot0) begin
        r_slot_vtx[0] <= bus.vertex_in;
        r_slot_mat[0] <= bus.material_in;
      end
      if (w_wr_slot1) begin
        r_slot_vtx[1] <= bus.vertex_in;
        r_slot_mat[1] <= bus.material_in;
      end
    end
  end

  assign w_tri_new    = {bus.vertex_in, r_slot_vtx[1], r_slot_vtx[0]};
  assign w_all_behind = le_zero(r_slot_vtx[0][3]) & le_zero(r_slot_vtx[1][3]) &
                        le_zero(bus.vertex_in[3]);
  assign w_cull       = (CULL_ENABLE != 0) & w_all_behind;

  // Extra pointer MSB separates full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && bus.ready_in;
  // A full FIFO still accepts when the head leaves on the same edge
  assign w_push  = w_complete && !w_cull && (!w_full || w_pop);
  assign w_drop  = w_complete && !w_cull && w_full && !w_pop;

  // Triangle FIFO storage and pointers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mem_tri <= '0;
      r_mem_mat <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      if (w_push) begin
        r_mem_tri[r_wptr[PTR_W-1:0]] <= w_tri_new;
        r_mem_mat[r_wptr[PTR_W-1:0]] <= r_slot_mat[0];
        r_wptr                       <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // Status: sticky overflow and saturating counters
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_overflow   <= 1'b0;
      r_culled_cnt <= '0;
      r_tri_cnt    <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_complete && w_cull && (r_culled_cnt != CNT_MAX))
        r_culled_cnt <= r_culled_cnt + CNT_W'(1);
      if (w_push && (r_tri_cnt != CNT_MAX))
        r_tri_cnt <= r_tri_cnt + CNT_W'(1);
    end
  end

  assign bus.valid_out        = !w_empty;
  assign bus.triangle_out     = r_mem_tri[r_rptr[PTR_W-1:0]];
  assign bus.material_out     = r_mem_mat[r_rptr[PTR_W-1:0]];
  assign bus.overflow_out     = r_overflow;
  assign bus.culled_count_out = r_culled_cnt;
  assign bus.tri_count_out    = r_tri_cnt;

endmodule
